// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, requester ids,
// access-size encodings and the alignment rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        ID_IFETCH = 1'b0,
        ID_DATA   = 1'b1
    } req_id_e;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    // Words need addr[1:0]==0, halves need addr[0]==0, bytes are always aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
               ((size == SZ_HALF) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the ifetch port, data port and shared-memory port.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rd_wr;
    logic [1:0]  d_size;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rd_wr;
    logic        mem_enable;
    logic [31:0] mem_data_out;
    logic        mem_busy;

    modport master (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_rd_wr, d_size,
               mem_data_out, mem_busy,
        output i_ack, i_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_data_in, mem_access_size, mem_rd_wr, mem_enable
    );

    modport slave (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_rd_wr, d_size,
               mem_data_out, mem_busy,
        input  i_ack, i_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_data_in, mem_access_size, mem_rd_wr, mem_enable
    );
endinterface

// File: rtl/mem_arbiter_pick2.sv
// Two-way grant selection. A lone requester always wins; on a tie the
// winner is either the port not granted last (RR_EN!=0) or the data port.
module arb_pick2
    import mem_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic    i_req_i,
    input  logic    d_req_i,
    input  req_id_e last_grant_i,
    output logic    valid_o,
    output req_id_e grant_o
);

    // Pure combinational pick; history only matters on a tie.
    always_comb begin
        valid_o = i_req_i | d_req_i;
        grant_o = ID_IFETCH;
        if (i_req_i && d_req_i) begin
            grant_o = ((RR_EN != 0) && (last_grant_i == ID_DATA)) ? ID_IFETCH : ID_DATA;
        end else if (d_req_i) begin
            grant_o = ID_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Ifetch/data arbiter in front of a single shared memory. One transaction
// in flight: IDLE samples and latches the winner, ISSUE drives memory,
// RDATA captures read data, RESP pulses the winner's ack for one cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    state_e      state_q, state_d;
    req_id_e     last_q, last_d;
    req_id_e     gnt_q, gnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_wr_q, rd_wr_d;
    logic [1:0]  size_q, size_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        pick_valid;
    req_id_e     pick_gnt;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_rd_wr;
    logic        sel_mis;
    logic        i_ack_w, d_ack_w;

    arb_pick2 #(.RR_EN(RR_EN)) u_pick (
        .i_req_i      (bus.i_req),
        .d_req_i      (bus.d_req),
        .last_grant_i (last_q),
        .valid_o      (pick_valid),
        .grant_o      (pick_gnt)
    );

    // Ifetch is always a word read.
    assign sel_addr  = (pick_gnt == ID_DATA) ? bus.d_addr    : bus.i_addr;
    assign sel_size  = (pick_gnt == ID_DATA) ? bus.d_size    : SZ_WORD;
    assign sel_rd_wr = (pick_gnt == ID_DATA) ? bus.d_rd_wr   : 1'b1;
    assign sel_mis   = misaligned(sel_size, sel_addr[1:0]);

    // Next-state and latch logic; registers hold unless the state acts on them.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_wr_d = rd_wr_q;
        size_d  = size_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    last_d  = pick_gnt;
                    gnt_d   = pick_gnt;
                    addr_d  = sel_addr;
                    size_d  = sel_size;
                    rd_wr_d = sel_rd_wr;
                    if (pick_gnt == ID_DATA) wdata_d = bus.d_wdata;
                    err_d   = sel_mis;
                    rdata_d = '0;
                    // Misaligned accesses never touch memory.
                    state_d = sel_mis ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.mem_busy) state_d = rd_wr_q ? ST_RDATA : ST_RESP;
            end
            ST_RDATA: begin
                rdata_d = bus.mem_data_out;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= ID_IFETCH;
            gnt_q   <= ID_IFETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_wr_q <= 1'b1;
            size_q  <= SZ_WORD;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_wr_q <= rd_wr_d;
            size_q  <= size_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign i_ack_w = (state_q == ST_RESP) && (gnt_q == ID_IFETCH);
    assign d_ack_w = (state_q == ST_RESP) && (gnt_q == ID_DATA);

    assign bus.i_ack   = i_ack_w;
    assign bus.d_ack   = d_ack_w;
    assign bus.i_rdata = i_ack_w ? rdata_q : '0;
    assign bus.d_rdata = d_ack_w ? rdata_q : '0;
    assign bus.d_err   = d_ack_w & err_q;

    // Memory side: address/data hold their last latched values; rd_wr idles high.
    assign bus.mem_enable      = (state_q == ST_ISSUE);
    assign bus.mem_rd_wr       = (state_q == ST_ISSUE) ? rd_wr_q : 1'b1;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_data_in     = wdata_q;
    assign bus.mem_access_size = size_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model (grant rule, latency formula,
// reference memory). A second instance with RR_EN=0 runs alongside.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if ifc ();
    mem_arbiter_if ifc_fp ();

    mem_arbiter #(.RR_EN(1)) u_dut (.clk(clk), .reset(reset), .bus(ifc.master));
    mem_arbiter #(.RR_EN(0)) u_fp  (.clk(clk), .reset(reset), .bus(ifc_fp.master));

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] phys      [logic [31:0]];   // memory as seen on the DUT bus
    logic [31:0] model_mem [logic [31:0]];   // reference model's memory

    // model state
    bit          last_d;
    bit          pend_i, pend_d;
    logic [31:0] ia, da, dw;
    logic        drw;
    logic [1:0]  dsz;

    // expectations for the memory bus of the current transaction
    logic [31:0] exp_addr, exp_wd;
    logic [1:0]  exp_sz;
    logic        exp_rw;
    int          busy_left, en_cnt;

    // fixed-priority instance observation
    int          fp_d = 0, fp_d_at_i = -1;
    bit          fp_i_done = 0;
    logic [31:0] fp_i_data = '0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == SZ_WORD) return (a % 4) != 0;
        if (sz == SZ_HALF) return (a % 2) != 0;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        phys[a] = v;
        model_mem[a] = v;
    endtask

    // Advance to the next falling edge and play memory for both instances.
    task automatic run_cycle();
        @(negedge clk);
        if (ifc.mem_enable) begin
            en_cnt++;
            chk("mem_addr", ifc.mem_addr, exp_addr);
            chk("mem_ctl", 32'({ifc.mem_rd_wr, ifc.mem_access_size}), 32'({exp_rw, exp_sz}));
            if (!exp_rw) chk("mem_wdata", ifc.mem_data_in, exp_wd);
            if (busy_left > 0) begin
                ifc.mem_busy = 1'b1;
                busy_left--;
            end else begin
                ifc.mem_busy = 1'b0;
                if (!ifc.mem_rd_wr) phys[ifc.mem_addr] = ifc.mem_data_in;
            end
        end else begin
            ifc.mem_busy = 1'b0;
            chk("idle_rd_wr", 32'(ifc.mem_rd_wr), 32'd1);
        end
        ifc.mem_data_out = phys.exists(ifc.mem_addr) ? phys[ifc.mem_addr] : dflt(ifc.mem_addr);
        chk("ack_excl", 32'(ifc.i_ack & ifc.d_ack), 32'd0);

        chk("fp_ack_excl", 32'(ifc_fp.i_ack & ifc_fp.d_ack), 32'd0);
        if (ifc_fp.d_ack) begin
            fp_d++;
            if (fp_d == 4) ifc_fp.d_req = 1'b0;
        end
        if (ifc_fp.i_ack && !fp_i_done) begin
            fp_i_done = 1'b1;
            fp_d_at_i = fp_d;
            fp_i_data = ifc_fp.i_rdata;
            ifc_fp.i_req = 1'b0;
        end
    endtask

    // One transaction from IDLE to ack, predicted from the grant rule,
    // the latency formula and the reference memory.
    task automatic do_txn(input int busy, input string tag);
        bit          win_d, mis, got_i, got_d;
        logic [31:0] a, exp_rd, obs_rd, other_rd;
        logic        obs_err;
        int          lat, cyc;
        ifc.i_req   = pend_i;
        ifc.i_addr  = ia;
        ifc.d_req   = pend_d;
        ifc.d_addr  = da;
        ifc.d_wdata = dw;
        ifc.d_rd_wr = drw;
        ifc.d_size  = dsz;

        win_d  = (pend_i && pend_d) ? !last_d : pend_d;
        last_d = win_d;
        if (win_d) begin
            a = da; exp_sz = dsz; exp_rw = drw; exp_wd = dw;
        end else begin
            a = ia; exp_sz = SZ_WORD; exp_rw = 1'b1; exp_wd = '0;
        end
        exp_addr = a;
        mis = ref_mis(exp_sz, a);
        exp_rd = (mis || !exp_rw) ? 32'd0 : (model_mem.exists(a) ? model_mem[a] : dflt(a));
        if (!mis && !exp_rw) model_mem[a] = exp_wd;
        lat = mis ? 1 : ((exp_rw ? 3 : 2) + busy);

        busy_left = busy;
        en_cnt = 0;
        cyc = 0;
        got_i = 0;
        got_d = 0;
        obs_rd = '0;
        obs_err = 1'b0;
        other_rd = '0;
        while (cyc < 40 && !got_i && !got_d) begin
            run_cycle();
            cyc++;
            got_i = ifc.i_ack;
            got_d = ifc.d_ack;
            obs_rd = got_d ? ifc.d_rdata : ifc.i_rdata;
            other_rd = got_d ? ifc.i_rdata : ifc.d_rdata;
            obs_err = ifc.d_err;
        end
        chk({tag, "_ack_seen"}, 32'(got_i | got_d), 32'd1);
        chk({tag, "_port"}, 32'(got_d), 32'(win_d));
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_rdata"}, obs_rd, exp_rd);
        chk({tag, "_other_rdata"}, other_rd, 32'd0);
        chk({tag, "_err"}, 32'(obs_err), 32'(win_d && mis));
        chk({tag, "_mem_en_cycles"}, 32'(en_cnt), mis ? 32'd0 : 32'(busy + 1));

        if (win_d) begin pend_d = 0; ifc.d_req = 1'b0; end
        else       begin pend_i = 0; ifc.i_req = 1'b0; end
        run_cycle();   // RESP -> IDLE
    endtask

    task automatic rand_i();
        ia = 32'h400 + 32'(4 * $urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) ia = ia + 32'($urandom_range(1, 3));
    endtask

    task automatic rand_d();
        da  = 32'h400 + 32'(4 * $urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) da = da + 32'($urandom_range(1, 3));
        dsz = 2'($urandom_range(0, 2));
        drw = 1'($urandom_range(0, 1));
        dw  = $urandom;
    endtask

    initial begin
        ifc.i_req = 0; ifc.i_addr = '0; ifc.d_req = 0; ifc.d_addr = '0;
        ifc.d_wdata = '0; ifc.d_rd_wr = 1; ifc.d_size = SZ_WORD;
        ifc.mem_busy = 0; ifc.mem_data_out = '0;
        // fixed-priority instance: both ports request from reset
        ifc_fp.i_req = 1; ifc_fp.i_addr = 32'h80; ifc_fp.d_req = 1;
        ifc_fp.d_addr = 32'h40; ifc_fp.d_wdata = 32'h0; ifc_fp.d_rd_wr = 0;
        ifc_fp.d_size = SZ_WORD; ifc_fp.mem_busy = 0; ifc_fp.mem_data_out = 32'h12345678;
        last_d = 0; pend_i = 0; pend_d = 0;
        ia = '0; da = '0; dw = '0; drw = 1; dsz = SZ_WORD;
        exp_addr = '0; exp_wd = '0; exp_sz = SZ_WORD; exp_rw = 1;
        busy_left = 0; en_cnt = 0;

        // reset state
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_i_ack", 32'(ifc.i_ack), 32'd0);
        chk("rst_d_ack", 32'(ifc.d_ack), 32'd0);
        chk("rst_d_err", 32'(ifc.d_err), 32'd0);
        chk("rst_i_rdata", ifc.i_rdata, 32'd0);
        chk("rst_d_rdata", ifc.d_rdata, 32'd0);
        chk("rst_mem_en", 32'(ifc.mem_enable), 32'd0);
        chk("rst_mem_rd_wr", 32'(ifc.mem_rd_wr), 32'd1);

        preload(32'h100, 32'h2402000A);
        preload(32'h104, 32'h11223344);

        // both held from reset, round robin: D, I, D, I
        reset = 0;
        ia = 32'h100;
        da = 32'h300; dw = 32'hCAFE0001; drw = 0; dsz = SZ_WORD;
        for (int k = 0; k < 4; k++) begin
            pend_i = 1; pend_d = 1;
            do_txn(0, "rr_tie");
            chk("rr_order", 32'(last_d), 32'((k % 2) == 0));
        end
        pend_i = 0; pend_d = 0;

        // ifetch word read
        pend_i = 1; ia = 32'h100;
        do_txn(0, "ifetch_read");

        // data write then read back
        pend_d = 1; da = 32'h200; dw = 32'hDEADBEEF; drw = 0; dsz = SZ_WORD;
        do_txn(0, "data_write");
        chk("phys_0x200", phys.exists(32'h200) ? phys[32'h200] : 32'hX, 32'hDEADBEEF);
        pend_d = 1; da = 32'h200; drw = 1; dsz = SZ_WORD;
        do_txn(0, "data_readback");

        // misaligned word and half
        pend_d = 1; da = 32'h202; drw = 1; dsz = SZ_WORD;
        do_txn(0, "mis_word");
        pend_d = 1; da = 32'h201; drw = 0; dsz = SZ_HALF; dw = 32'h5555AAAA;
        do_txn(0, "mis_half");
        pend_d = 1; da = 32'h203; drw = 0; dsz = SZ_BYTE; dw = 32'h000000A5;
        do_txn(0, "byte_write");

        // ifetch read stalled four cycles
        pend_i = 1; ia = 32'h104;
        do_txn(4, "ifetch_busy");

        // random traffic
        for (int k = 0; k < 40; k++) begin
            if (!pend_i && $urandom_range(0, 2) != 0) begin pend_i = 1; rand_i(); end
            if (!pend_d && $urandom_range(0, 2) != 0) begin pend_d = 1; rand_d(); end
            if (!pend_i && !pend_d) begin pend_d = 1; rand_d(); end
            do_txn(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "rnd");
        end
        // drain a loser left pending
        while (pend_i || pend_d) do_txn(0, "drain");

        // fixed priority: data won every tie until it dropped
        chk("fp_i_granted", 32'(fp_i_done), 32'd1);
        chk("fp_data_first", 32'(fp_d_at_i), 32'd4);
        chk("fp_i_rdata", fp_i_data, 32'h12345678);

        // reset during RDATA abandons the read
        da = 32'h200; drw = 1; dsz = SZ_WORD;
        exp_addr = da; exp_rw = 1; exp_sz = SZ_WORD; busy_left = 0;
        ifc.d_addr = da; ifc.d_rd_wr = 1; ifc.d_size = SZ_WORD; ifc.d_req = 1;
        run_cycle();   // ISSUE
        run_cycle();   // RDATA
        reset = 1;
        ifc.d_req = 0;
        run_cycle();
        chk("rst_mid_i_ack", 32'(ifc.i_ack), 32'd0);
        chk("rst_mid_d_ack", 32'(ifc.d_ack), 32'd0);
        chk("rst_mid_mem_en", 32'(ifc.mem_enable), 32'd0);
        reset = 0;
        run_cycle();
        chk("post_rst_d_ack", 32'(ifc.d_ack), 32'd0);
        chk("post_rst_mem_en", 32'(ifc.mem_enable), 32'd0);
        last_d = 0;
        // fresh tie after reset: data wins again
        pend_i = 1; ia = 32'h100;
        pend_d = 1; da = 32'h200; drw = 1; dsz = SZ_WORD;
        do_txn(0, "post_rst_tie");
        do_txn(0, "post_rst_ifetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin on ties; 0 = fixed priority, data port over ifetch.
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  ifetch request, held until i_ack.
REQ-005 i_addr  input  32  ifetch byte address.
REQ-006 i_ack  output  1  one-cycle ifetch completion pulse.
REQ-007 i_rdata  output  32  ifetch read data, valid only while i_ack=1.
REQ-008 d_req  input  1  data request, held until d_ack.
REQ-009 d_addr  input  32  data byte address.
REQ-010 d_wdata  input  32  data write value.
REQ-011 d_rd_wr  input  1  1 = read, 0 = write.
REQ-012 d_size  input  2  access size (sz_word/sz_half/sz_byte).
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  32  data read value, valid only while d_ack=1.
REQ-015 d_err  output  1  misalignment flag, valid only while d_ack=1.
REQ-016 mem_addr, mem_data_in  output  32 each  address and write data to the shared memory.
REQ-017 mem_access_size  output  2; mem_rd_wr  output  1; mem_enable  output  1.
REQ-018 mem_data_out  input  32; mem_busy  input  1  shared memory read data and stall.

Function
REQ-019 States: IDLE, ISSUE, RDATA, RESP; one transaction in flight at a time.
REQ-020 IDLE: requests are sampled only in IDLE; the winner's address, data, rd_wr and size are latched; next state is ISSUE, or RESP when misaligned.
REQ-021 Ifetch is always a word read (size sz_word, rd_wr=1).
REQ-022 Tie (both req=1 in IDLE): RR_EN=1 grants the port not granted last; RR_EN=0 grants data.
REQ-023 Single requester is granted regardless of history.
REQ-024 Misaligned = sz_word with addr[1:0]!=0, or sz_half with addr[0]!=0; no memory access; RESP with err=1 and rdata=0.
REQ-025 ISSUE: mem_enable=1; mem outputs driven from the latched registers; stay while mem_busy=1.
REQ-026 ISSUE, mem_busy=0 at the edge: read goes to RDATA, write goes to RESP.
REQ-027 RDATA: mem_data_out is captured into the response register; next state is RESP.
REQ-028 RESP: the granted port's ack=1 for exactly one cycle; next state is IDLE; req inputs are ignored.
REQ-029 Requester deasserts req on the edge where it sees ack=1; a req high in IDLE is a new request.
REQ-030 Minimum latency, req in IDLE to ack: read = 3 cycles, write = 2 cycles, misaligned = 1 cycle; each mem_busy cycle adds one.
REQ-031 Outside ISSUE: mem_enable=0, mem_rd_wr=1, mem_addr and mem_data_in hold the last latched values.
REQ-032 i_ack and d_ack are never both 1; a non-granted port's ack, rdata and err stay 0.
REQ-033 last_grant updates only on a grant in IDLE, including misaligned grants.
REQ-034 Deasserting req before ack is a protocol violation; the latched transaction still completes and acks.

Reset
REQ-035 In the cycle after reset=1: state=IDLE; i_ack=d_ack=d_err=0; i_rdata=d_rdata=0; mem_enable=0; mem_rd_wr=1; last_grant=ifetch (data wins the first tie).
REQ-036 Reset mid-transaction abandons it with no ack; a write in ISSUE may or may not have reached memory.

Structure
REQ-037 Shared package mem_arb_pkg holds the state enum, the requester-id enum and the access-size constants (the same values as sz_word/sz_half/sz_byte).
REQ-038 Tie-break logic lives in a sub-module arb_pick2 (two requests, last_grant and RR_EN in; grant out).

Verification
REQ-039 i_req=1, i_addr=0x100, mem word 0x100=0x2402000A, mem_busy=0 -> i_ack on cycle 3, i_rdata=0x2402000A, mem_enable high one cycle.
REQ-040 d_req write, addr 0x200, wdata 0xDEADBEEF, sz_word -> d_ack on cycle 2; memory 0x200 reads back 0xDEADBEEF.
REQ-041 Both req held from reset, RR_EN=1 -> grants D,I,D,I; RR_EN=0 -> all data grants until d_req drops.
REQ-042 d_req sz_word addr 0x202 -> d_ack cycle 1, d_err=1, mem_enable never asserted.
REQ-043 mem_busy=1 for 4 cycles during an ifetch read -> i_ack on cycle 7, address stable throughout.
REQ-044 reset asserted in RDATA -> no ack; IDLE next cycle; a fresh request completes normally.
